// File: rtl/modulus_counter_prog.sv
// Programmable up/down modulus counter with run-time terminal value, clamped load,
// combinational terminal count for cascading and a registered wrap pulse.
// Optional prescaler enabled by defining MODCNT_PRESCALE_EN.
module modulus_counter_prog #(
    parameter int WIDTH        = 8,
    parameter int DEFAULT_LAST = 52,
    parameter int PRESCALE_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  last_wr,
    input  logic [WIDTH-1:0]      last_val,
`ifdef MODCNT_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] presc_div,
`endif
    output logic [WIDTH-1:0]      Q,
    output logic [WIDTH-1:0]      last_q,
    output logic                  tc,
    output logic                  wrap
);

    if (WIDTH < 2 || PRESCALE_W < 1 || DEFAULT_LAST < 0 || DEFAULT_LAST >= (1 << WIDTH)) begin : g_paramCheck
        $error("modulus_counter_prog: illegal parameter combination");
    end

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_last;
    logic             r_wrap;

    logic             w_stepOk;
    logic             w_step;
    logic             w_outRange;
    logic             w_wrapCond;
    logic [WIDTH-1:0] w_loadClamped;

`ifdef MODCNT_PRESCALE_EN
    logic [PRESCALE_W-1:0] r_presc;

    assign w_stepOk = (r_presc == presc_div);

    // Prescaler only advances on enabled cycles; a load restarts the divide period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (load) begin
            r_presc <= '0;
        end else if (enable) begin
            if (w_stepOk) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PRESCALE_W'(1);
            end
        end
    end
`else
    assign w_stepOk = 1'b1;
`endif

    assign w_step        = enable & w_stepOk;
    assign w_outRange    = (r_count > r_last);
    assign w_loadClamped = (load_val > r_last) ? r_last : load_val;

    // An out-of-range count is treated like the boundary so it recovers on the next step.
    assign w_wrapCond = up_dn ? ((r_count == r_last) | w_outRange)
                              : ((r_count == '0) | w_outRange);

    assign tc = w_step & w_wrapCond & ~load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (load) begin
            r_count <= w_loadClamped;
            r_wrap  <= 1'b0;
        end else if (w_step) begin
            r_wrap <= w_wrapCond;
            if (w_wrapCond) begin
                r_count <= up_dn ? '0 : r_last;
            end else if (up_dn) begin
                r_count <= r_count + WIDTH'(1);
            end else begin
                r_count <= r_count - WIDTH'(1);
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    // The new terminal value is only seen by steps and loads from the next cycle on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= WIDTH'(DEFAULT_LAST);
        end else if (last_wr) begin
            r_last <= last_val;
        end
    end

    assign Q      = r_count;
    assign last_q = r_last;
    assign wrap   = r_wrap;

endmodule

// File: doc/modulus_counter_prog.md
# modulus_counter_prog

Programmable up/down modulus counter: the parametrised successor to the fixed-modulus counter in the counters library. It counts 0..`last` inclusive in either direction, takes a run-time terminal value, supports synchronous load, and provides a terminal-count output for cascading plus a registered wrap pulse. It sits in timer, divider and frame-position logic, where the modulus changes at run time and counters chain.

## Interface
- `WIDTH`, 8, counter and terminal-value width in bits (≥ 2)
- `DEFAULT_LAST`, 52, terminal value loaded on reset (must be < 2^WIDTH)
- `PRESCALE_W`, 4, prescaler divide-field width (used only with `MODCNT_PRESCALE_EN`)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `enable`  in  1  count enable, active high; cascade input
- `up_dn`  in  1  direction, 1 = up, 0 = down
- `load`  in  1  synchronous load strobe
- `load_val`  in  WIDTH  value for `load`
- `last_wr`  in  1  terminal-value write strobe
- `last_val`  in  WIDTH  new terminal value
- `presc_div`  in  PRESCALE_W  divide-minus-one (present only with `MODCNT_PRESCALE_EN`)
- `Q`  out  WIDTH  current count
- `last_q`  out  WIDTH  current terminal value
- `tc`  out  1  combinational terminal count: the next step wraps
- `wrap`  out  1  registered one-cycle pulse after each wrap

## Operation
- Reset (async, active high): `Q` = 0, `last_q` = `DEFAULT_LAST`, `wrap` = 0, prescaler = 0.
- A step is the event `enable` & `step_ok`. `step_ok` = 1 without the macro.
- Priority each cycle: `load` > step > hold.
- Load: `Q` <= `load_val` if `load_val` ≤ `last_q`. Otherwise `Q` <= `last_q` (clamped). Load never sets `wrap` and clears the prescaler.
- Up step: `Q` == `last_q` -> 0 with wrap. `Q` > `last_q` (out of range) -> 0 with wrap. Otherwise `Q` + 1.
- Down step: `Q` == 0 -> `last_q` with wrap. `Q` > `last_q` -> `last_q` with wrap. Otherwise `Q` − 1.
- `last_wr`: `last_q` <= `last_val` at the edge. A step or load in the same cycle uses the old `last_q`. The new value governs from the next cycle.
- `last_q` = 0: `Q` stays 0 and every step wraps.
- `tc` = step & wrap-condition. It is purely combinational from `Q`, `last_q`, `up_dn`, `enable`, the prescaler and `load`, and is forced 0 when `load` = 1. Chain counters by driving a downstream `enable` from an upstream `tc`.
- All arithmetic is WIDTH-bit unsigned. No intermediate overflow is possible because the +1/−1 boundaries are handled explicitly.

## Timing
- `Q`, `last_q` and `wrap` update on the rising `clk` edge. Latency from step to new `Q` is 1 cycle.
- `wrap` goes high in the cycle after the edge that wrapped `Q`, and lasts exactly 1 cycle per wrap. Back-to-back wraps (e.g. `last_q` = 0) hold `wrap` high continuously.
- `tc` is valid in the same cycle as its inputs and has zero latency. A cascade of N stages adds N combinational levels.
- `up_dn` may change on any cycle. It takes effect on the next step.
- Reset mid-count takes effect immediately and asynchronously. Deassertion must be synchronous to `clk` (handled by the system reset synchroniser).

## Configuration
- `MODCNT_PRESCALE_EN` defined:
  - Adds `presc_div` and a PRESCALE_W-bit prescaler that advances on every `enable` cycle.
  - `step_ok` = 1 when prescaler == `presc_div`; the prescaler then returns to 0.
  - `Q` therefore steps once per `presc_div`+1 enabled cycles.
  - `presc_div` = 0 behaves as no prescaling.
  - The prescaler holds when `enable` = 0, and clears on `load` and `reset`.
- Undefined: no `presc_div` port and no prescaler logic; every enabled cycle is a step.

## Test plan
- Reset, `enable` = 1, `up_dn` = 1, 60 cycles -> `Q` runs 0..52, then 0..6. `tc` is high only when `Q` = 52. `wrap` is high in the cycle after `Q` = 52 -> 0.
- `up_dn` = 0 from reset -> `Q` sequence 0, 52, 51, … with `tc` high when `Q` = 0. `wrap` pulses after 0 -> 52.
- At `Q` = 30, write `last_val` = 9 while stepping up -> `Q` = 31. Next step -> 0 with wrap, then 0..9 repeating.
- `load` = 1, `load_val` = 200, `last_q` = 52, `enable` = 1 -> `Q` = 52 (clamped). `wrap` = 0 and `tc` = 0 in the load cycle.
- Two stages: stage A `last` = 3 drives stage B `enable` via `tc` -> B increments once per 4 cycles, B `last` = 2 -> B sequence 0,1,2,0 over 12 cycles.
- With `MODCNT_PRESCALE_EN`, `presc_div` = 3 -> `Q` steps every 4th cycle. Dropping `enable` for 2 cycles delays the step by 2. Asserting `reset` mid-count -> `Q` = 0 and prescaler = 0 immediately.
